// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared opcodes, FSM states and defaults for the branch resolver
package branch_pkg;

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  localparam int DEF_FLUSH_SLOTS = 1;
  localparam int DEF_WAIT_MAX    = 15;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch decode and condition evaluation
import branch_pkg::*;

module branch_cmp (
  input  logic [5:0]  opcode,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        is_branch,
  output logic        taken,
  output logic        needs_rt
);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    needs_rt  = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_branch = 1'b1;
        needs_rt  = 1'b1;
        taken     = (rs == rt);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        needs_rt  = 1'b1;
        taken     = (rs != rt);
      end
      // Signed compares against zero reduce to sign bit and zero test.
      OP_BLEZ: begin
        is_branch = 1'b1;
        taken     = rs[31] | (rs == 32'd0);
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        taken     = ~rs[31] & (rs != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - ID-stage branch resolver driving PC advance/redirect; BRANCH_STATS_EN adds taken/not-taken counters
import branch_pkg::*;

module branch_resolve #(
  parameter int FLUSH_SLOTS = DEF_FLUSH_SLOTS,
  parameter int WAIT_MAX    = DEF_WAIT_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [15:0] id_imm16,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  output logic        steve,
  output logic        npc_sel,
  output logic [15:0] imm16_out,
  output logic        flush,
  output logic        wd_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] nottaken_cnt
`endif
);

  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_SLOTS - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  flush_cnt;
  logic        is_branch, cond_taken, needs_rt;
  logic        br_valid, ops_ready;
  logic        capture, resolve_nt, wd_fire;

  branch_cmp u_cmp (
    .opcode    (id_opcode),
    .rs        (id_rs_val),
    .rt        (id_rt_val),
    .is_branch (is_branch),
    .taken     (cond_taken),
    .needs_rt  (needs_rt)
  );

  assign br_valid  = id_valid & is_branch;
  assign ops_ready = rs_ready & (rt_ready | ~needs_rt);

  always_comb begin
    state_nxt  = state;
    steve      = 1'b1;
    npc_sel    = 1'b0;
    flush      = 1'b0;
    capture    = 1'b0;
    resolve_nt = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (br_valid) begin
          if (!ops_ready) begin
            // Hold the PC in the detect cycle itself, not one cycle late.
            steve     = 1'b0;
            state_nxt = S_WAIT;
          end else if (cond_taken) begin
            capture   = 1'b1;
            state_nxt = S_REDIRECT;
          end else begin
            resolve_nt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        steve = 1'b0;
        if (!br_valid) begin
          state_nxt = S_IDLE;
        end else if (ops_ready) begin
          if (cond_taken) begin
            capture   = 1'b1;
            state_nxt = S_REDIRECT;
          end else begin
            resolve_nt = 1'b1;
            state_nxt  = S_IDLE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          wd_fire    = 1'b1;
          resolve_nt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_REDIRECT: begin
        npc_sel   = 1'b1;
        state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == FLUSH_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      imm16_out <= 16'd0;
      wait_cnt  <= 8'd0;
      flush_cnt <= 3'd0;
      wd_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd_err    <= wd_fire;
      wait_cnt  <= (state == S_WAIT)  ? wait_cnt + 8'd1  : 8'd0;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 3'd1 : 3'd0;
      if (capture) imm16_out <= id_imm16;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt    <= 32'd0;
      nottaken_cnt <= 32'd0;
    end else begin
      if (capture)    taken_cnt    <= taken_cnt + 32'd1;
      if (resolve_nt) nottaken_cnt <= nottaken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = 6'h00;
  logic [15:0] id_imm16 = 16'h0000;
  logic [31:0] id_rs_val = 32'h0;
  logic [31:0] id_rt_val = 32'h0;
  logic        rs_ready = 1'b1;
  logic        rt_ready = 1'b1;

  logic        steve, npc_sel, flush, wd_err;
  logic [15:0] imm16_out;
  logic        steve3, npc_sel3, flush3, wd_err3;
  logic [15:0] imm16_out3;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt, nottaken_cnt, taken_cnt3, nottaken_cnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_imm16(id_imm16), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .steve(steve), .npc_sel(npc_sel),
    .imm16_out(imm16_out), .flush(flush), .wd_err(wd_err)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  branch_resolve #(.FLUSH_SLOTS(3), .WAIT_MAX(15)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_imm16(id_imm16), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .steve(steve3), .npc_sel(npc_sel3),
    .imm16_out(imm16_out3), .flush(flush3), .wd_err(wd_err3)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt3), .nottaken_cnt(nottaken_cnt3)
`endif
  );

  task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr);
    id_valid = v; id_opcode = op; id_imm16 = imm;
    id_rs_val = rs; id_rt_val = rt; rs_ready = rsr; rt_ready = rtr;
  endtask

  task automatic idle_in;
    drive(1'b0, 6'h00, 16'h0000, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL rst_steve: got %b want 1", steve); end
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL rst_npc_sel: got %b want 0", npc_sel); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
    checks++; if (imm16_out !== 16'h0000) begin errors++; $display("FAIL rst_imm: got %h want 0000", imm16_out); end
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL rst_wd: got %b want 0", wd_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken;
    drive(1'b1, 6'h04, 16'h0003, 32'h5, 32'h5, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL beq_det_steve: got %b want 1", steve); end
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL beq_det_npc: got %b want 0", npc_sel); end
    tick();
    drive(1'b1, 6'h04, 16'h0009, 32'h5, 32'h5, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL beq_redir_npc: got %b want 1", npc_sel); end
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL beq_redir_steve: got %b want 1", steve); end
    checks++; if (imm16_out !== 16'h0003) begin errors++; $display("FAIL beq_redir_imm: got %h want 0003", imm16_out); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_redir_flush: got %b want 0", flush); end
    tick();
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b want 1", flush); end
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL beq_flush_npc: got %b want 0", npc_sel); end
    checks++; if (imm16_out !== 16'h0003) begin errors++; $display("FAIL beq_flush_imm: got %h want 0003", imm16_out); end
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_after_flush: got %b want 0", flush); end
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL beq_after_steve: got %b want 1", steve); end
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL beq_after_npc: got %b want 0", npc_sel); end
    checks++; if (imm16_out !== 16'h0003) begin errors++; $display("FAIL beq_after_imm: got %h want 0003", imm16_out); end
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 6'h05, 16'h0044, 32'h7, 32'h7, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL bne_steve: got %b want 1", steve); end
    tick();
    drive(1'b1, 6'h04, 16'h0005, 32'h2, 32'h2, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL bne_npc: got %b want 0", npc_sel); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bne_flush: got %b want 0", flush); end
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL b2b_steve: got %b want 1", steve); end
    checks++; if (imm16_out !== 16'h0003) begin errors++; $display("FAIL bne_imm_hold: got %h want 0003", imm16_out); end
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL b2b_npc: got %b want 1", npc_sel); end
    checks++; if (imm16_out !== 16'h0005) begin errors++; $display("FAIL b2b_imm: got %h want 0005", imm16_out); end
    tick();
    @(negedge clk);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush: got %b want 1", flush); end
    tick();
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_idle_flush: got %b want 0", flush); end
    tick();
  endtask

  task automatic test_signed_zero;
    drive(1'b1, 6'h07, 16'h0020, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL bgtz_steve: got %b want 1", steve); end
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL bgtz_npc: got %b want 0", npc_sel); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bgtz_flush: got %b want 0", flush); end
    tick();
    drive(1'b1, 6'h06, 16'h0021, 32'h0, 32'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL blez_steve: got %b want 1", steve); end
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL blez_npc: got %b want 1", npc_sel); end
    checks++; if (imm16_out !== 16'h0021) begin errors++; $display("FAIL blez_imm: got %h want 0021", imm16_out); end
    tick();
    tick();
  endtask

  task automatic test_stall;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 6'h04, 16'h0010, 32'h1, 32'h1, (c == 3), 1'b1);
      @(negedge clk);
      checks++; if (steve !== 1'b0) begin errors++; $display("FAIL stall_steve c=%0d: got %b want 0", c, steve); end
      tick();
    end
    idle_in();
    @(negedge clk);
    checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL stall_npc: got %b want 1", npc_sel); end
    checks++; if (steve !== 1'b1) begin errors++; $display("FAIL stall_redir_steve: got %b want 1", steve); end
    checks++; if (imm16_out !== 16'h0010) begin errors++; $display("FAIL stall_imm: got %h want 0010", imm16_out); end
    tick();
    tick();
  endtask

  task automatic test_watchdog;
    int pulses = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1'b1, 6'h04, 16'h0030, 32'h1, 32'h2, 1'b1, 1'b0);
      else idle_in();
      @(negedge clk);
      pulses += int'(wd_err);
      checks++; if (steve !== (c >= 16)) begin errors++; $display("FAIL wd_steve c=%0d: got %b want %b", c, steve, (c >= 16)); end
      checks++; if (wd_err !== (c == 16)) begin errors++; $display("FAIL wd_err c=%0d: got %b want %b", c, wd_err, (c == 16)); end
      checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL wd_npc c=%0d: got %b want 0", c, npc_sel); end
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wd_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_valid_drop;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b1, 6'h05, 16'h0040, 32'h1, 32'h2, 1'b0, 1'b1);
      else idle_in();
      @(negedge clk);
      checks++; if (steve !== (c >= 3)) begin errors++; $display("FAIL drop_steve c=%0d: got %b want %b", c, steve, (c >= 3)); end
      checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL drop_npc c=%0d: got %b want 0", c, npc_sel); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL drop_flush c=%0d: got %b want 0", c, flush); end
      tick();
    end
  endtask

  task automatic test_reset_redirect;
    drive(1'b1, 6'h04, 16'h0055, 32'h9, 32'h9, 1'b1, 1'b1);
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL rr_pre_npc: got %b want 1", npc_sel); end
    #1 reset = 1'b1;
    #1;
    checks++; if (npc_sel !== 1'b0) begin errors++; $display("FAIL rr_npc: got %b want 0", npc_sel); end
    checks++; if (imm16_out !== 16'h0000) begin errors++; $display("FAIL rr_imm: got %h want 0000", imm16_out); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_flush;
    drive(1'b1, 6'h04, 16'h0077, 32'h3, 32'h3, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    @(negedge clk);
    checks++; if (flush3 !== 1'b1) begin errors++; $display("FAIL rf_pre_flush3: got %b want 1", flush3); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rf_slot1_flush: got %b want 0", flush); end
    #1 reset = 1'b1;
    #1;
    checks++; if (steve3 !== 1'b1) begin errors++; $display("FAIL rf_steve3: got %b want 1", steve3); end
    checks++; if (npc_sel3 !== 1'b0) begin errors++; $display("FAIL rf_npc3: got %b want 0", npc_sel3); end
    checks++; if (flush3 !== 1'b0) begin errors++; $display("FAIL rf_flush3: got %b want 0", flush3); end
    checks++; if (imm16_out3 !== 16'h0000) begin errors++; $display("FAIL rf_imm3: got %h want 0000", imm16_out3); end
`ifdef BRANCH_STATS_EN
    checks++; if (taken_cnt3 !== 32'd0) begin errors++; $display("FAIL rf_taken3: got %0d want 0", taken_cnt3); end
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats;
    drive(1'b1, 6'h04, 16'h0001, 32'h4, 32'h4, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    drive(1'b1, 6'h05, 16'h0002, 32'h4, 32'h4, 1'b1, 1'b1);
    tick();
    idle_in();
    @(negedge clk);
    checks++; if (taken_cnt !== 32'd1) begin errors++; $display("FAIL st_taken: got %0d want 1", taken_cnt); end
    checks++; if (nottaken_cnt !== 32'd1) begin errors++; $display("FAIL st_nottaken: got %0d want 1", nottaken_cnt); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_beq_taken();
    test_back_to_back();
    test_signed_zero();
    test_stall();
    test_watchdog();
    test_valid_drop();
    test_reset_redirect();
    test_reset_flush();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Decode-stage branch resolver; the control end of the PC-update interface.
- Evaluates conditional branches in ID and drives the PC unit's advance enable (steve), branch select (npc_sel) and word offset (imm16_out).
- Stalls the PC while branch operands are pending, then issues a one-cycle redirect and squashes wrong-path fetch slots.
- Sits between the ID pipeline register and the PC unit. The PC unit samples its controls on negedge clk; this block updates state on posedge clk.

Parameters:
- FLUSH_SLOTS, 1: cycles of flush asserted after a redirect (1..7).
- WAIT_MAX, 15: maximum operand-wait cycles before the watchdog fires (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a valid instruction.
- id_opcode  input  6  opcode of the ID instruction.
- id_imm16  input  16  branch offset field.
- id_rs_val  input  32  rs operand.
- id_rt_val  input  32  rt operand.
- rs_ready  input  1  rs is not pending from an in-flight load.
- rt_ready  input  1  rt is not pending from an in-flight load.
- steve  output  1  PC advance enable: 1 = advance, 0 = hold.
- npc_sel  output  1  1 = PC takes the branch-target path on this advance.
- imm16_out  output  16  captured branch offset presented to the PC unit.
- flush  output  1  squash the IF/ID register.
- wd_err  output  1  one-cycle pulse when the watchdog abandons a wait.

Behaviour:
- States: IDLE, WAIT, REDIRECT, FLUSH. Reset (async) forces IDLE, imm16_out=0, wait and flush counters 0.
- Branch opcodes and conditions:
  - BEQ 6'h04: taken if rs==rt.
  - BNE 6'h05: taken if rs!=rt.
  - BLEZ 6'h06: taken if signed rs<=0.
  - BGTZ 6'h07: taken if signed rs>0.
  - All other opcodes are non-branch.
- Operands needed: BEQ/BNE need rs_ready&rt_ready. BLEZ/BGTZ need rs_ready only; rt_ready is ignored.
- IDLE:
  - steve=1, npc_sel=0, flush=0, unless a valid branch is present with operands not ready; then steve=0 combinationally in that same cycle.
  - Branch, operands ready, taken: capture id_imm16 and go to REDIRECT.
  - Branch, operands ready, not taken: stay in IDLE.
  - Branch, operands not ready: clear the wait counter and go to WAIT.
- WAIT:
  - steve=0, npc_sel=0. The wait counter increments each cycle.
  - When the needed operands become ready, evaluate with the current values. Taken: capture id_imm16 and go to REDIRECT. Not taken: go to IDLE, with steve=1 from the next cycle.
  - If the counter reaches WAIT_MAX with operands still not ready: pulse wd_err, go to IDLE, treat the branch as not taken.
  - If id_valid drops in WAIT: return to IDLE, no redirect.
- REDIRECT: exactly one cycle. steve=1, npc_sel=1, imm16_out holds the captured offset. Next state is FLUSH.
- FLUSH: FLUSH_SLOTS cycles. flush=1, steve=1, npc_sel=0. A valid branch in ID during FLUSH is ignored (wrong path). Next state is IDLE.
- Back-to-back branches:
  - After a not-taken branch, a branch in the next cycle is evaluated normally.
  - After a taken branch, the first branch evaluated is the one arriving in IDLE after FLUSH.
- Outputs steve, npc_sel and flush are decoded from state; the only Mealy term is the IDLE stall above. Outputs are stable before negedge.
- imm16_out changes only on capture. It holds its value otherwise, so the PC unit sees a stable offset during REDIRECT.
- Reset mid-REDIRECT or mid-FLUSH abandons the redirect; npc_sel=0 immediately.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds two 32-bit outputs, taken_cnt and nottaken_cnt, both reset to 0.
  - taken_cnt increments on each entry to REDIRECT.
  - nottaken_cnt increments on each not-taken resolution, including watchdog aborts.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- branch_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ;
  - state encodings S_IDLE, S_WAIT, S_REDIRECT, S_FLUSH;
  - default FLUSH_SLOTS and WAIT_MAX values.
- One sub-module, branch_cmp: combinational; takes opcode, rs and rt; outputs is_branch, taken, needs_rt.

Test Plan:
- BEQ, rs=rt=32'h5, both ready, imm16=16'h0003 -> REDIRECT next cycle with npc_sel=1, imm16_out=16'h0003; flush=1 for 1 cycle; then IDLE with steve=1.
- BNE, rs=rt=32'h7 -> not taken: npc_sel stays 0, flush never asserts, steve stays 1.
- BGTZ, rs=32'h8000_0000, rt_ready=0 -> not taken, because the signed compare is negative and rt_ready is ignored.
- BEQ with rs_ready=0 for 3 cycles, then rs=rt=32'h1 ready -> steve=0 for 4 cycles including detect, then REDIRECT.
- BEQ with rt_ready held 0 and WAIT_MAX=15 -> wd_err pulses once after 15 WAIT cycles, return to IDLE, steve=1, no redirect.
- reset asserted during FLUSH with FLUSH_SLOTS=3 -> outputs go to IDLE values (steve=1, npc_sel=0, flush=0) immediately; with BRANCH_STATS_EN, taken_cnt reads 0.
